// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared widths, word typedefs and helpers for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 36;
    localparam int STAT_W     = 16;

    typedef logic [MEM_ADDR_W-1:0]        mem_addr_t;
    typedef logic signed [MEM_DATA_W-1:0] mem_data_t;

    // Index width for a requester count; never collapses to zero bits.
    function automatic int ptr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Requester handshake, response and memory-port bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W
);

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_we;
    logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [DATA_W-1:0]               rsp_data;
    logic [ADDR_W-1:0]               mem_addr;
    logic [DATA_W-1:0]               mem_wdata;
    logic                            mem_we;
    logic                            mem_re;
    logic [DATA_W-1:0]               mem_rdata;
    logic [NUM_REQ-1:0][STAT_W-1:0]  stat_grant_cnt;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_data,
        output mem_addr, mem_wdata, mem_we, mem_re, stat_grant_cnt
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_addr, mem_wdata, mem_we, mem_re, stat_grant_cnt
    );

endinterface

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module   : rr_picker
// Brief    : Round-robin one-hot picker starting the search at the pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, ptr} + SUM_W'(off);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Single-port memory arbiter: DSP priority, round-robin, anti-starve.
// Config   : define MEM_ARB_STATS_EN for per-requester 16-bit grant counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   wait_q [NUM_REQ];
    logic [CNT_W-1:0]   wait_d [NUM_REQ];
    logic [NUM_REQ-1:0] rr_req, rr_gnt, starve_gnt, grant;
    logic               starve_hit;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic [NUM_REQ-1:0] rd_own_q, rd_own_d, rsp_valid_q, rsp_valid_d;

    assign rr_req = bus.req_valid & {{(NUM_REQ-1){1'b1}}, 1'b0};

    rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req (rr_req),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt)
    );

    // Starvation beats the DSP core; the DSP core beats round-robin.
    always_comb begin
        starve_gnt = '0;
        starve_hit = 1'b0;
        for (int i = 1; i < NUM_REQ; i++) begin
            if (!starve_hit && bus.req_valid[i] && wait_q[i] == CNT_W'(STARVE_LIMIT)) begin
                starve_gnt[i] = 1'b1;
                starve_hit    = 1'b1;
            end
        end
        grant = '0;
        if (!reset_n) begin
            grant = '0;
        end else if (starve_hit) begin
            grant = starve_gnt;
        end else if (bus.req_valid[0]) begin
            grant[0] = 1'b1;
        end else begin
            grant = rr_gnt;
        end
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        rd_own_d    = '0;
        rr_ptr_d    = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = '0;
            if (grant[i]) begin
                mem_addr_d  = bus.req_addr[i];
                mem_wdata_d = bus.req_wdata[i];
                mem_we_d    = bus.req_we[i];
                mem_re_d    = !bus.req_we[i];
                rd_own_d[i] = !bus.req_we[i];
                if (i != 0) begin
                    rr_ptr_d = (i == NUM_REQ - 1) ? PTR_W'(1) : PTR_W'(i + 1);
                end
            end
            if (i != 0 && !grant[i]) begin
                wait_d[i] = wait_q[i];
                if (bus.req_valid[i] && wait_q[i] != CNT_W'(STARVE_LIMIT)) begin
                    wait_d[i] = wait_q[i] + 1'b1;
                end
            end
        end
        rsp_valid_d = rd_own_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= PTR_W'(1);
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            rd_own_q    <= '0;
            rsp_valid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            rd_own_q    <= rd_own_d;
            rsp_valid_q <= rsp_valid_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = reset_n ? bus.mem_rdata : '0;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;

`ifdef MEM_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        logic [STAT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (grant[g] && cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign bus.stat_grant_cnt[g] = cnt_q;
    end
`else
    assign bus.stat_grant_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: requester count (2..8); index 0 is the DSP core.
REQ-002 SHALL have parameter ADDR_W, default 10: memory word address width.
REQ-003 SHALL have parameter DATA_W, default 36: signed memory word width.
REQ-004 SHALL have parameter STARVE_LIMIT, default 15: wait cycles before a low-priority requester preempts requester 0.
REQ-005 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester access request.
REQ-008 SHALL have port req_we  input  NUM_REQ  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  NUM_REQ x ADDR_W  per-requester address.
REQ-010 SHALL have port req_wdata  input  NUM_REQ x DATA_W  per-requester write data.
REQ-011 SHALL have port req_ready  output  NUM_REQ  one-hot grant; transfer occurs when valid and ready are both high.
REQ-012 SHALL have port rsp_valid  output  NUM_REQ  one-hot read-data strobe.
REQ-013 SHALL have port rsp_data  output  DATA_W  read data shared by all requesters.
REQ-014 SHALL have ports mem_addr (ADDR_W), mem_wdata (DATA_W), mem_we (1) and mem_re (1), all outputs: the single memory port.
REQ-015 SHALL have port mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_re.
REQ-016 SHALL have port stat_grant_cnt  output  NUM_REQ x 16  per-requester grant counters (see Configuration).

Function
REQ-017 SHALL grant at most one requester per cycle; req_ready SHALL be a combinational function of req_valid and registered state.
REQ-018 SHALL grant requester 0 whenever it is valid, unless some requester is starving.
REQ-019 SHALL arbitrate requesters 1..NUM_REQ-1 round-robin when requester 0 is idle; the pointer advances to winner+1 (wrapping) only on a grant.
REQ-020 SHALL keep a saturating wait counter per requester 1..NUM_REQ-1: increment when valid and not granted; clear on grant.
REQ-021 SHALL treat a requester as starving when its counter equals STARVE_LIMIT; the lowest-index starving requester SHALL preempt requester 0 for one grant.
REQ-022 SHALL drive mem_addr, mem_wdata, mem_we and mem_re from registers loaded in the handshake cycle T, so they are valid at T+1; mem_we and mem_re SHALL be 0 on cycles with no grant.
REQ-023 SHALL assert rsp_valid for the originating requester at T+2 for reads, with rsp_data = mem_rdata (combinational pass-through); writes SHALL produce no rsp_valid.
REQ-024 SHALL sustain one access per cycle; back-to-back reads from different requesters SHALL return in grant order.
REQ-025 SHALL not check requester protocol: requesters hold valid, we, addr and wdata stable until ready.

Reset
REQ-026 SHALL on reset_n low immediately clear req_ready, rsp_valid, mem_we, mem_re, all wait counters and stat counters, and set the round-robin pointer to 1.
REQ-027 SHALL drive mem_addr, mem_wdata and rsp_data to 0 during reset; reads in flight at reset SHALL be discarded, with no rsp_valid after release.

Configuration
REQ-028 SHALL implement grant statistics when MEM_ARB_STATS_EN is defined: each requester's 16-bit counter increments on its handshake and saturates at 0xFFFF.
REQ-029 SHALL tie stat_grant_cnt to 0 and instantiate no counter logic when MEM_ARB_STATS_EN is undefined.

Structure
REQ-030 SHALL take ADDR_W and DATA_W defaults and the typedefs mem_addr_t and mem_data_t from shared package mem_arb_pkg.
REQ-031 SHALL implement round-robin selection in sub-module rr_picker (request vector and pointer in, one-hot grant out).

Verification
REQ-032 SHALL cover: requester 0 reads addr 0x005 while the memory holds 0x0_0000_0ABC -> mem_re at T+1, rsp_valid[0] and rsp_data=0x0_0000_0ABC at T+2.
REQ-033 SHALL cover: requesters 1 and 2 held valid, requester 0 idle -> grants alternate 1,2,1,2 on consecutive cycles.
REQ-034 SHALL cover: requester 0 valid continuously with requester 2 valid -> requester 2 is granted on exactly the 16th cycle of waiting, then requester 0 resumes.
REQ-035 SHALL cover: requester 1 writes 0x8_0000_0001 to 0x3FF, then requester 2 reads 0x3FF -> rsp_data=0x8_0000_0001 and no rsp_valid for the write.
REQ-036 SHALL cover: reset_n pulsed low at T+1 of a read -> no rsp_valid after release, and all outputs are 0 during reset.
REQ-037 SHALL cover, with MEM_ARB_STATS_EN: 70000 grants to requester 1 -> stat_grant_cnt[1]=0xFFFF.
